hsv_core_mem_inflight: RTL and testbench
========================================

Name: hsv_core_mem_inflight

Overview:
Parametrised in-flight transaction tracker for the core memory unit. It is the next generation of the fixed pending_reads/pending_writes/write_balance counter trio.
- Records the word address of every AXI read and write that has been issued but not yet completed.
- Decides per cycle whether a new read or write may issue, using address-granular hazards instead of blanket read/write serialisation.
- Owns the flush_req/flush_ack handshake.
- Sits between the mem request stage (issue side), the response stage (completion side) and the commit interface (write balance).

Parameters:
RD_DEPTH, 4, maximum outstanding AXI reads (≥1)
WR_DEPTH, 4, maximum outstanding AXI writes (≥1)
GRAN_LOG2, 2, hazard granularity; addresses compared on bits [31:GRAN_LOG2]
BAL_W, 4, width of signed write_balance counter

Ports:
clk_core  in  1  core clock
rst_core_n  in  1  asynchronous active-low reset
flush_req  in  1  pipeline flush request
flush_ack  out  1  registered; flush may proceed, clears all state
issue_valid  in  1  request stage has an AXI AR/AW handshake this cycle
issue_write  in  1  1=write, 0=read
issue_addr  in  32  byte address of transaction
read_ok  out  1  comb; a read to issue_addr may issue now
write_ok  out  1  comb; a write to issue_addr may issue now
rd_done  in  1  R handshake (rvalid&rready) retires oldest read
wr_done  in  1  B handshake retires oldest write
bal_up  in  1  response stage forwarded an unstarted write to commit
pending_reads  out  $clog2(RD_DEPTH+1)  outstanding reads
pending_writes  out  $clog2(WR_DEPTH+1)  outstanding writes
write_balance  out  BAL_W signed  committed-but-unissued writes
idle  out  1  pending_reads==0 & pending_writes==0 & write_balance==0
err  out  1  sticky protocol error

Behaviour:
- Reset (asynchronous): both tables empty; counters 0; err 0; flush_ack 1.
- Read table and write table: independent circular FIFOs of valid+tag (tag = issue_addr[31:GRAN_LOG2]). Pointers wrap modulo depth. Completions within one channel are in order (single AXI ID 0).
- read_ok = read table not full & no valid write entry with matching tag.
- write_ok = write table not full & no valid read entry with matching tag & write_balance > 0. write_balance is the registered value; bal_up in the same cycle does not count.
- Allocate on issue_valid & (issue_write ? write_ok : read_ok). Takes effect next cycle: the entry is pushed and the count incremented.
- issue_valid without the corresponding ok: no allocation, err set. The caller must gate on ok.
- A write allocation decrements write_balance. bal_up increments it. Both in one cycle: net zero.
- rd_done/wr_done pop the head entry next cycle. Pop and push in the same cycle on one table: count unchanged, both pointers advance.
- Pop on an empty table: ignored, err set.
- write_balance signed arithmetic. It may go negative only via a sequence of bal_up/decrement orders; increment from max positive saturates and sets err.
- Hazard compare is against registered table state. A same-cycle completion does not unblock the same-cycle issue (one-cycle conservative).
- flush_ack <= flush_req & idle (registered, one-cycle latency).
- While flush_ack=1: tables cleared, counters to 0, issue ignored. err is not cleared by flush, only by reset.
- Reset mid-transaction: all state dropped immediately; the AXI side is reset by the same rst_core_n.

Optional Feature:
HSV_CORE_MEM_RELAXED_ORDER_EN
- Defined: address-granular hazard checking as above.
- Undefined: legacy ordering. read_ok requires pending_writes==0; write_ok requires pending_reads==0 (plus the full and balance checks). Tag storage and comparators are not synthesised; the tables degenerate to counters.

Decomposition:
- hsv_core_pkg gains: mem_tag_t (logic [31:GRAN_LOG2] via localparam), mem_inflight_err_t, MEM_INFLIGHT_* default localparams.
- Sub-module hsv_core_mem_tag_fifo (parametrised DEPTH, push/pop, count, full/empty, comb "match" output for a query tag), instantiated once for reads and once for writes.

Test Plan:
1. Reset, then issue read 0x100, read 0x104, RD_DEPTH=2 → pending_reads=2, read_ok=0 for 0x200. rd_done → next cycle pending_reads=1, read_ok=1.
2. bal_up ×1, write 0x40 issued → write_balance 1→0, pending_writes=1. Read query 0x42 (GRAN_LOG2=2) → read_ok=0; read query 0x80 → read_ok=1 (RELAXED defined) / 0 (undefined).
3. write_balance=0, query write 0x10 → write_ok=0. bal_up same cycle as write issue attempt → no allocation, err=1.
4. Simultaneous wr_done, write issue (balance=1) and bal_up with pending_writes=1 → pending_writes stays 1, write_balance stays 1, pointers advance.
5. flush_req held with pending_reads=1 → flush_ack=0. rd_done → flush_ack=1 two cycles after rd_done, state zeroed.
6. BAL_W=4, 7 bal_up then one more → write_balance stays 7, err=1. Assert rst_core_n low mid-sequence → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/hsv_core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hsv_core_pkg: shared types and defaults for the core memory unit           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package hsv_core_pkg;

  localparam int MEM_INFLIGHT_RD_DEPTH = 4;
  localparam int MEM_INFLIGHT_WR_DEPTH = 4;
  localparam int MEM_INFLIGHT_GRAN_LOG2 = 2;
  localparam int MEM_INFLIGHT_BAL_W = 4;

  typedef logic [31:MEM_INFLIGHT_GRAN_LOG2] mem_tag_t;

  typedef struct packed {
    logic issue_blocked;
    logic pop_empty;
    logic bal_sat;
  } mem_inflight_err_t;

endpackage
`default_nettype wire

// File: rtl/hsv_core_mem_tag_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hsv_core_mem_tag_fifo: circular valid+tag table with associative match     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module hsv_core_mem_tag_fifo #(
  parameter int DEPTH    = 4,
  parameter int TAG_W    = 30,
  parameter bit USE_TAGS = 1'b1
) (
  input  logic                       clk_core,
  input  logic                       rst_core_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic [TAG_W-1:0]           push_tag,
  input  logic                       pop,
  input  logic [TAG_W-1:0]           query_tag,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       match
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= f_next(r_wr_ptr);
      if (pop)  r_rd_ptr <= f_next(r_rd_ptr);
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign count = r_count;
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);

  generate
    if (USE_TAGS) begin : g_tags
      logic [DEPTH-1:0] r_valid;
      logic [TAG_W-1:0] r_tag [DEPTH];

      // Clear before set so a same-slot pop/push leaves the slot valid.
      always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
          r_valid <= '0;
        end else if (clr) begin
          r_valid <= '0;
        end else begin
          if (pop)  r_valid[r_rd_ptr] <= 1'b0;
          if (push) r_valid[r_wr_ptr] <= 1'b1;
        end
      end

      always_ff @(posedge clk_core) begin
        if (push && !clr) r_tag[r_wr_ptr] <= push_tag;
      end

      always_comb begin
        match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
          if (r_valid[i] && (r_tag[i] == query_tag)) match = 1'b1;
        end
      end
    end else begin : g_no_tags
      logic w_unused_tags;
      assign w_unused_tags = ^{push_tag, query_tag};
      assign match = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/hsv_core_mem_inflight.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hsv_core_mem_inflight: outstanding AXI read/write tracker, hazards, flush  |
// | Option macro HSV_CORE_MEM_RELAXED_ORDER_EN: address-granular hazards.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module hsv_core_mem_inflight
  import hsv_core_pkg::*;
#(
  parameter int RD_DEPTH  = MEM_INFLIGHT_RD_DEPTH,
  parameter int WR_DEPTH  = MEM_INFLIGHT_WR_DEPTH,
  parameter int GRAN_LOG2 = MEM_INFLIGHT_GRAN_LOG2,
  parameter int BAL_W     = MEM_INFLIGHT_BAL_W
) (
  input  logic                          clk_core,
  input  logic                          rst_core_n,
  input  logic                          flush_req,
  output logic                          flush_ack,
  input  logic                          issue_valid,
  input  logic                          issue_write,
  input  logic [31:0]                   issue_addr,
  output logic                          read_ok,
  output logic                          write_ok,
  input  logic                          rd_done,
  input  logic                          wr_done,
  input  logic                          bal_up,
  output logic [$clog2(RD_DEPTH+1)-1:0] pending_reads,
  output logic [$clog2(WR_DEPTH+1)-1:0] pending_writes,
  output logic signed [BAL_W-1:0]       write_balance,
  output logic                          idle,
  output logic                          err
);

  localparam int TAG_W = 32 - GRAN_LOG2;
  localparam logic [BAL_W-1:0] c_bal_max = {1'b0, {(BAL_W-1){1'b1}}};

`ifdef HSV_CORE_MEM_RELAXED_ORDER_EN
  localparam bit c_use_tags = 1'b1;
`else
  localparam bit c_use_tags = 1'b0;
`endif

  logic [TAG_W-1:0]  w_tag;
  logic              r_flush_ack;
  logic              r_err;
  logic [BAL_W-1:0]  r_bal;
  logic              w_rd_full, w_rd_empty, w_rd_match;
  logic              w_wr_full, w_wr_empty, w_wr_match;
  logic              w_bal_pos;
  logic              w_active;
  logic              w_rd_push, w_rd_pop, w_wr_push, w_wr_pop;
  mem_inflight_err_t w_err_cause;
  logic              w_unused_addr;

  assign w_tag         = issue_addr[31:GRAN_LOG2];
  assign w_unused_addr = ^issue_addr;
  assign w_bal_pos     = ~r_bal[BAL_W-1] & (|r_bal);
  // All table traffic is dropped in the cycle the flush is acknowledged.
  assign w_active      = ~r_flush_ack;

`ifdef HSV_CORE_MEM_RELAXED_ORDER_EN
  assign read_ok  = ~w_rd_full & ~w_wr_match;
  assign write_ok = ~w_wr_full & ~w_rd_match & w_bal_pos;
`else
  logic w_unused_match;
  assign w_unused_match = w_rd_match ^ w_wr_match;
  assign read_ok  = ~w_rd_full & (pending_writes == '0);
  assign write_ok = ~w_wr_full & (pending_reads == '0) & w_bal_pos;
`endif

  assign w_rd_push = w_active & issue_valid & ~issue_write & read_ok;
  assign w_wr_push = w_active & issue_valid &  issue_write & write_ok;
  assign w_rd_pop  = w_active & rd_done & ~w_rd_empty;
  assign w_wr_pop  = w_active & wr_done & ~w_wr_empty;

  hsv_core_mem_tag_fifo #(
    .DEPTH    (RD_DEPTH),
    .TAG_W    (TAG_W),
    .USE_TAGS (c_use_tags)
  ) u_rd_table (
    .clk_core   (clk_core),
    .rst_core_n (rst_core_n),
    .clr        (r_flush_ack),
    .push       (w_rd_push),
    .push_tag   (w_tag),
    .pop        (w_rd_pop),
    .query_tag  (w_tag),
    .count      (pending_reads),
    .full       (w_rd_full),
    .empty      (w_rd_empty),
    .match      (w_rd_match)
  );

  hsv_core_mem_tag_fifo #(
    .DEPTH    (WR_DEPTH),
    .TAG_W    (TAG_W),
    .USE_TAGS (c_use_tags)
  ) u_wr_table (
    .clk_core   (clk_core),
    .rst_core_n (rst_core_n),
    .clr        (r_flush_ack),
    .push       (w_wr_push),
    .push_tag   (w_tag),
    .pop        (w_wr_pop),
    .query_tag  (w_tag),
    .count      (pending_writes),
    .full       (w_wr_full),
    .empty      (w_wr_empty),
    .match      (w_wr_match)
  );

  always_comb begin
    w_err_cause               = '0;
    w_err_cause.issue_blocked = issue_valid & ~(issue_write ? write_ok : read_ok);
    w_err_cause.pop_empty     = (rd_done & w_rd_empty) | (wr_done & w_wr_empty);
    w_err_cause.bal_sat       = bal_up & ~w_wr_push & (r_bal == c_bal_max);
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      r_flush_ack <= 1'b1;
      r_err       <= 1'b0;
      r_bal       <= '0;
    end else begin
      r_flush_ack <= flush_req & idle;
      r_err       <= r_err | (w_active & (|w_err_cause));
      if (r_flush_ack) begin
        r_bal <= '0;
      end else if (bal_up && !w_wr_push) begin
        if (r_bal != c_bal_max) r_bal <= r_bal + 1'b1;
      end else if (w_wr_push && !bal_up) begin
        r_bal <= r_bal - 1'b1;
      end
    end
  end

  assign flush_ack     = r_flush_ack;
  assign err           = r_err;
  assign write_balance = r_bal;
  assign idle          = (pending_reads == '0) & (pending_writes == '0) & (r_bal == '0);

endmodule
`default_nettype wire

// File: tb/tb_hsv_core_mem_inflight.sv
`default_nettype none
// Bench for hsv_core_mem_inflight: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then constrained-random traffic.
module tb_hsv_core_mem_inflight;

  localparam int RD = 2;
  localparam int WR = 3;
  localparam int G = 2;
  localparam int BW = 4;
  localparam int BAL_MAX = 7;
`ifdef HSV_CORE_MEM_RELAXED_ORDER_EN
  localparam bit RELAXED = 1'b1;
`else
  localparam bit RELAXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_req = 1'b0;
  logic flush_ack;
  logic issue_valid = 1'b0;
  logic issue_write = 1'b0;
  logic [31:0] issue_addr = '0;
  logic read_ok, write_ok;
  logic rd_done = 1'b0;
  logic wr_done = 1'b0;
  logic bal_up = 1'b0;
  logic [1:0] pending_reads;
  logic [1:0] pending_writes;
  logic signed [BW-1:0] write_balance;
  logic idle, err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hsv_core_mem_inflight #(
    .RD_DEPTH (RD), .WR_DEPTH (WR), .GRAN_LOG2 (G), .BAL_W (BW)
  ) dut (
    .clk_core (clk), .rst_core_n (rst_n),
    .flush_req (flush_req), .flush_ack (flush_ack),
    .issue_valid (issue_valid), .issue_write (issue_write), .issue_addr (issue_addr),
    .read_ok (read_ok), .write_ok (write_ok),
    .rd_done (rd_done), .wr_done (wr_done), .bal_up (bal_up),
    .pending_reads (pending_reads), .pending_writes (pending_writes),
    .write_balance (write_balance), .idle (idle), .err (err)
  );

  // ---------------- reference model ----------------
  logic [31:0] rq[$];
  logic [31:0] wq[$];
  int  m_bal = 0;
  bit  m_err = 1'b0;
  bit  m_ack = 1'b1;
  bit  m_nack, m_rok, m_wok, m_rpush, m_wpush;

  function automatic bit m_read_ok(input logic [31:0] a);
    bit haz = 1'b0;
    if (RELAXED) begin
      foreach (wq[i]) if (wq[i] == (a >> G)) haz = 1'b1;
    end else begin
      haz = (wq.size() != 0);
    end
    return (rq.size() < RD) && !haz;
  endfunction

  function automatic bit m_write_ok(input logic [31:0] a);
    bit haz = 1'b0;
    if (RELAXED) begin
      foreach (rq[i]) if (rq[i] == (a >> G)) haz = 1'b1;
    end else begin
      haz = (rq.size() != 0);
    end
    return (wq.size() < WR) && !haz && (m_bal > 0);
  endfunction

  function automatic bit m_idle();
    return (rq.size() == 0) && (wq.size() == 0) && (m_bal == 0);
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      rq.delete(); wq.delete();
      m_bal = 0; m_err = 1'b0; m_ack = 1'b1;
    end else begin
      m_nack = flush_req && m_idle();
      if (m_ack) begin
        rq.delete(); wq.delete();
        m_bal = 0;
      end else begin
        m_rok = m_read_ok(issue_addr);
        m_wok = m_write_ok(issue_addr);
        m_rpush = issue_valid && !issue_write && m_rok;
        m_wpush = issue_valid && issue_write && m_wok;
        if (issue_valid && !(issue_write ? m_wok : m_rok)) m_err = 1'b1;
        if (rd_done) begin
          if (rq.size() == 0) m_err = 1'b1; else void'(rq.pop_front());
        end
        if (wr_done) begin
          if (wq.size() == 0) m_err = 1'b1; else void'(wq.pop_front());
        end
        if (m_rpush) rq.push_back(issue_addr >> G);
        if (m_wpush) wq.push_back(issue_addr >> G);
        if (bal_up && !m_wpush) begin
          if (m_bal == BAL_MAX) m_err = 1'b1; else m_bal++;
        end else if (m_wpush && !bal_up) begin
          m_bal--;
        end
      end
      m_ack = m_nack;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("flush_ack", flush_ack, m_ack);
    chk("pending_reads", pending_reads, rq.size());
    chk("pending_writes", pending_writes, wq.size());
    chk("write_balance", $signed(write_balance), m_bal);
    chk("idle", idle, m_idle());
    chk("err", err, m_err);
    chk("read_ok", read_ok, m_read_ok(issue_addr));
    chk("write_ok", write_ok, m_write_ok(issue_addr));
  endtask

  initial forever begin
    @(negedge clk);
    check_all();
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input bit w, input logic [31:0] a,
                       input bit rd, input bit wd, input bit bu, input bit fr);
    issue_valid = v; issue_write = w; issue_addr = a;
    rd_done = rd; wr_done = wd; bal_up = bu; flush_req = fr;
  endtask

  task automatic cyc(input bit v, input bit w, input logic [31:0] a,
                     input bit rd, input bit wd, input bit bu, input bit fr);
    drive(v, w, a, rd, wd, bu, fr);
    @(posedge clk); #1;
  endtask

  task automatic query(input bit w, input logic [31:0] a);
    drive(1'b0, w, a, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  logic [31:0] ra;
  bit rw, rv, rok;

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("lit_reset_ack", flush_ack, 1);
    chk("lit_reset_err", err, 0);
    chk("lit_reset_pr", pending_reads, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("lit_ack_drop", flush_ack, 0);

    // read table fills at depth 2, then a retirement frees a slot
    cyc(1, 0, 32'h100, 0, 0, 0, 0);
    cyc(1, 0, 32'h104, 0, 0, 0, 0);
    query(0, 32'h200);
    chk("lit_t1_pr2", pending_reads, 2);
    chk("lit_t1_rok_full", read_ok, 0);
    cyc(0, 0, 32'h200, 1, 0, 0, 0);
    query(0, 32'h200);
    chk("lit_t1_pr1", pending_reads, 1);
    chk("lit_t1_rok", read_ok, 1);
    cyc(0, 0, 0, 1, 0, 0, 0);

    // write hazard at word granularity
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(1, 1, 32'h40, 0, 0, 0, 0);
    chk("lit_t2_bal", $signed(write_balance), 0);
    chk("lit_t2_pw", pending_writes, 1);
    query(0, 32'h42);
    chk("lit_t2_rok_same", read_ok, 0);
    query(0, 32'h80);
    chk("lit_t2_rok_other", read_ok, RELAXED ? 1 : 0);

    // zero balance blocks writes; blocked issue flags err
    query(1, 32'h10);
    chk("lit_t3_wok", write_ok, 0);
    cyc(1, 1, 32'h10, 0, 0, 1, 0);
    chk("lit_t3_err", err, 1);
    chk("lit_t3_pw", pending_writes, 1);
    chk("lit_t3_bal", $signed(write_balance), 1);

    // simultaneous push/pop/bal_up
    cyc(1, 1, 32'h20, 0, 1, 1, 0);
    chk("lit_t4_pw", pending_writes, 1);
    chk("lit_t4_bal", $signed(write_balance), 1);
    query(0, 32'h20);
    chk("lit_t4_rok_new", read_ok, 0);
    query(0, 32'h40);
    chk("lit_t4_rok_old", read_ok, RELAXED ? 1 : 0);
    cyc(0, 0, 0, 0, 1, 0, 0);

    // flush waits for idle
    cyc(1, 1, 32'h30, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 32'h300, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("lit_t5_ack0a", flush_ack, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("lit_t5_ack0b", flush_ack, 0);
    cyc(0, 0, 0, 1, 0, 0, 1);
    chk("lit_t5_ack0c", flush_ack, 0);
    chk("lit_t5_pr0", pending_reads, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("lit_t5_ack1", flush_ack, 1);
    chk("lit_t5_idle", idle, 1);
    cyc(1, 0, 32'h500, 0, 0, 0, 0);
    chk("lit_t5_ignored", pending_reads, 0);
    chk("lit_t5_ackdrop", flush_ack, 0);

    // balance saturation, then async reset mid-cycle
    do_reset();
    chk("lit_t6_err0", err, 0);
    repeat (7) cyc(0, 0, 0, 0, 0, 1, 0);
    chk("lit_t6_bal7", $signed(write_balance), 7);
    chk("lit_t6_err_pre", err, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("lit_t6_sat", $signed(write_balance), 7);
    chk("lit_t6_err", err, 1);
    cyc(1, 0, 32'h100, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_t6_rst_pr", pending_reads, 0);
    chk("lit_t6_rst_bal", $signed(write_balance), 0);
    chk("lit_t6_rst_err", err, 0);
    chk("lit_t6_rst_ack", flush_ack, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // constrained-random traffic
    for (int i = 0; i < 2500; i++) begin
      if (i % 250 == 249) begin
        drive(0, 0, 0, 0, 0, 0, 0);
        #($urandom_range(1, 3)) rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
      end
      rw = $urandom_range(0, 1);
      ra = ($urandom_range(0, 7) << G) | $urandom_range(0, 3);
      rok = rw ? m_write_ok(ra) : m_read_ok(ra);
      rv = rok ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 40) == 0);
      cyc(rv, rw, ra,
          (rq.size() != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0),
          (wq.size() != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0),
          $urandom_range(0, 2) == 0,
          $urandom_range(0, 15) == 0);
    end

    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
